// File: rtl/organ_pkg.sv
// Shared definitions for the organ tone-generation path.
package organ_pkg;

    localparam int unsigned DEFAULT_CNT_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

endpackage

// File: rtl/tone_divider.sv
// Run-time programmable, glitch-free clock divider for one organ voice.
// Divisor changes and start/stop only ever take effect at output edges.
module tone_divider
    import organ_pkg::*;
#(
    parameter int unsigned CNT_W        = DEFAULT_CNT_W,
    parameter int unsigned DEFAULT_HALF = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] half_period,
    output logic             clk_out,
    output logic             tick,
    output logic             idle
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   half_q, half_d;
    logic [CNT_W-1:0]   pend_val_q, pend_val_d;
    logic               pend_q, pend_d;
    logic               clk_out_q, clk_out_d;
    logic               tick_q, tick_d;
    logic               idle_q, idle_d;
    logic               toggle_c;

    assign toggle_c = (state_q != ST_IDLE) && (count_q == half_q);

    // Next-state: counter, divisor staging and run/stop control.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        clk_out_d  = clk_out_q;
        tick_d     = 1'b0;

        if (load) begin
            pend_val_d = half_period;
        end

        unique case (state_q)
            ST_IDLE: begin
                count_d   = '0;
                clk_out_d = 1'b0;
                if (load) begin
                    half_d = half_period;
                end else if (pend_q) begin
                    half_d = pend_val_q;
                end
                pend_d = 1'b0;
                if (en) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN, ST_STOP: begin
                // Divisor only changes at an edge so no half-period is altered.
                if (toggle_c) begin
                    if (load) begin
                        half_d = half_period;
                    end else if (pend_q) begin
                        half_d = pend_val_q;
                    end
                    pend_d = 1'b0;
                end else if (load) begin
                    pend_d = 1'b1;
                end

                if (!en && !clk_out_q) begin
                    state_d   = ST_IDLE;
                    count_d   = '0;
                    clk_out_d = 1'b0;
                end else begin
                    if (toggle_c) begin
                        count_d   = '0;
                        clk_out_d = ~clk_out_q;
                        tick_d    = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end

                    if (en) begin
                        state_d = ST_RUN;
                    end else if (toggle_c && clk_out_q) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                count_d   = '0;
                clk_out_d = 1'b0;
            end
        endcase

        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            half_q     <= CNT_W'(DEFAULT_HALF);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            idle_q     <= idle_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign idle    = idle_q;

endmodule

// File: tb/tb_tone_divider.sv
// Directed bench for tone_divider: reset, loads, stop/cancel and minimum divisor.
module tb_tone_divider;

    localparam int unsigned CNT_W = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             load;
    logic [CNT_W-1:0] half_period;
    logic             clk_out;
    logic             tick;
    logic             idle;

    int tests  = 0;
    int failed = 0;

    tone_divider #(.CNT_W(CNT_W), .DEFAULT_HALF(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .half_period(half_period),
        .clk_out    (clk_out),
        .tick       (tick),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; half_period = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_half(input logic [CNT_W-1:0] v);
        load = 1'b1; half_period = v;
        step();
        load = 1'b0; half_period = '0;
    endtask

    task automatic test_reset();
        logic exp_clk, exp_tick;
        rst = 1'b1; en = 1'b0; load = 1'b0; half_period = '0;
        step();
        step();
        tests++;
        if ({clk_out, tick, idle} !== 3'b001) begin
            failed++;
            $display("FAIL reset_vals clk_out/tick/idle=%b expected 001", {clk_out, tick, idle});
        end
        rst = 1'b0;
        step();
        tests++;
        if (idle !== 1'b1) begin
            failed++;
            $display("FAIL reset_idle_hold idle=%b expected 1", idle);
        end
        en = 1'b1;
        step();
        tests++;
        if ({clk_out, idle} !== 2'b00) begin
            failed++;
            $display("FAIL reset_enable clk_out/idle=%b expected 00", {clk_out, idle});
        end
        // Default half of 1: rise at n=3, fall at n=5, period 4.
        for (int n = 2; n <= 9; n++) begin
            step();
            exp_clk  = (((n - 1) / 2) % 2) == 1;
            exp_tick = (n % 2) == 1;
            tests++;
            if ({clk_out, tick, idle} !== {exp_clk, exp_tick, 1'b0}) begin
                failed++;
                $display("FAIL reset_default_wave n=%0d clk_out/tick/idle=%b expected %b",
                         n, {clk_out, tick, idle}, {exp_clk, exp_tick, 1'b0});
            end
        end
        // clk_out is low here, so dropping en stops immediately.
        en = 1'b0;
        step();
        tests++;
        if ({clk_out, tick, idle} !== 3'b001) begin
            failed++;
            $display("FAIL stop_low_immediate clk_out/tick/idle=%b expected 001", {clk_out, tick, idle});
        end
        step();
        tests++;
        if ({clk_out, tick, idle} !== 3'b001) begin
            failed++;
            $display("FAIL stop_low_quiet clk_out/tick/idle=%b expected 001", {clk_out, tick, idle});
        end
    endtask

    task automatic test_load_running();
        logic exp_clk, exp_tick;
        do_reset();
        set_half(20'd4);
        en = 1'b1;
        for (int n = 1; n <= 8; n++) step();
        tests++;
        if (clk_out !== 1'b1) begin
            failed++;
            $display("FAIL load_run_pre clk_out=%b expected 1", clk_out);
        end
        load = 1'b1; half_period = 20'd9;
        for (int n = 9; n <= 32; n++) begin
            step();
            load = 1'b0; half_period = '0;
            exp_clk  = (n < 11) || (n >= 21 && n < 31);
            exp_tick = (n == 11) || (n == 21) || (n == 31);
            tests++;
            if ({clk_out, tick} !== {exp_clk, exp_tick}) begin
                failed++;
                $display("FAIL load_run_wave n=%0d clk_out/tick=%b expected %b",
                         n, {clk_out, tick}, {exp_clk, exp_tick});
            end
        end
    endtask

    task automatic test_load_coincident();
        logic exp_clk, exp_tick;
        do_reset();
        set_half(20'd4);
        en = 1'b1;
        step();
        step();
        load = 1'b1; half_period = 20'd7;
        step();
        load = 1'b0; half_period = '0;
        step();
        step();
        load = 1'b1; half_period = 20'd2;
        for (int n = 6; n <= 16; n++) begin
            step();
            load = 1'b0; half_period = '0;
            exp_clk  = (n < 9) || (n >= 12 && n < 15);
            exp_tick = (n == 6) || (n == 9) || (n == 12) || (n == 15);
            tests++;
            if ({clk_out, tick} !== {exp_clk, exp_tick}) begin
                failed++;
                $display("FAIL load_coincident n=%0d clk_out/tick=%b expected %b",
                         n, {clk_out, tick}, {exp_clk, exp_tick});
            end
        end
    endtask

    task automatic test_stop_high();
        logic exp_clk, exp_tick, exp_idle;
        do_reset();
        set_half(20'd5);
        en = 1'b1;
        for (int n = 1; n <= 8; n++) step();
        tests++;
        if (clk_out !== 1'b1) begin
            failed++;
            $display("FAIL stop_high_pre clk_out=%b expected 1", clk_out);
        end
        en = 1'b0;
        for (int n = 9; n <= 20; n++) begin
            step();
            exp_clk  = (n < 13);
            exp_tick = (n == 13);
            exp_idle = (n >= 13);
            tests++;
            if ({clk_out, tick, idle} !== {exp_clk, exp_tick, exp_idle}) begin
                failed++;
                $display("FAIL stop_high n=%0d clk_out/tick/idle=%b expected %b",
                         n, {clk_out, tick, idle}, {exp_clk, exp_tick, exp_idle});
            end
        end
    endtask

    task automatic test_stop_cancel();
        logic exp_clk, exp_tick;
        do_reset();
        set_half(20'd5);
        en = 1'b1;
        for (int n = 1; n <= 8; n++) step();
        en = 1'b0;
        for (int n = 9; n <= 26; n++) begin
            step();
            if (n == 10) en = 1'b1;
            exp_clk  = (n < 13) || (n >= 19 && n < 25);
            exp_tick = (n == 13) || (n == 19) || (n == 25);
            tests++;
            if ({clk_out, tick, idle} !== {exp_clk, exp_tick, 1'b0}) begin
                failed++;
                $display("FAIL stop_cancel n=%0d clk_out/tick/idle=%b expected %b",
                         n, {clk_out, tick, idle}, {exp_clk, exp_tick, 1'b0});
            end
        end
    endtask

    task automatic test_min_and_reset();
        logic exp_clk;
        do_reset();
        set_half(20'd0);
        en = 1'b1;
        step();
        for (int n = 2; n <= 6; n++) begin
            step();
            exp_clk = (n % 2) == 0;
            tests++;
            if ({clk_out, tick} !== {exp_clk, 1'b1}) begin
                failed++;
                $display("FAIL min_divisor n=%0d clk_out/tick=%b expected %b",
                         n, {clk_out, tick}, {exp_clk, 1'b1});
            end
        end
        rst = 1'b1;
        step();
        tests++;
        if ({clk_out, tick, idle} !== 3'b001) begin
            failed++;
            $display("FAIL midrun_reset clk_out/tick/idle=%b expected 001", {clk_out, tick, idle});
        end
        // half_reg back to 1: first rise two cycles after entering RUN.
        rst = 1'b0;
        step();
        step();
        tests++;
        if ({clk_out, idle} !== 2'b00) begin
            failed++;
            $display("FAIL reset_half_low clk_out/idle=%b expected 00", {clk_out, idle});
        end
        step();
        tests++;
        if ({clk_out, tick} !== 2'b11) begin
            failed++;
            $display("FAIL reset_half_rise clk_out/tick=%b expected 11", {clk_out, tick});
        end
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; half_period = '0;
        test_reset();
        test_load_running();
        test_load_coincident();
        test_stop_high();
        test_stop_cancel();
        test_min_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
